// File: rtl/mvm3_result_quant_buf.sv
// mvm3_result_quant_buf
//   Downstream stage of the 3x3 matrix-vector multiplier. Accepts 16-bit signed
//   results over valid/ready, optionally applies ReLU, shifts arithmetically right
//   by SHIFT, saturates to signed 8 bits and buffers the result in a small FIFO.
//   Each FIFO entry carries three flags: overflow, saturation and last-of-vector.
//
// Ports
//   i_clk                       clock, all state updates on posedge
//   i_reset                     synchronous active-high reset
//   i_s_valid / o_s_ready       upstream handshake (multiplier m_valid / m_ready)
//   i_data_in [15:0]            signed upstream result
//   i_ovf_in                    upstream MAC overflow, qualified by i_s_valid
//   o_m_valid / i_m_ready       downstream handshake
//   o_data_out [7:0]            signed quantised result
//   o_ovf_out                   overflow flag stored with this entry
//   o_sat_out                   saturation clipped this entry
//   o_m_last                    entry is result NROWS_A-1 of its vector
//
// Configuration
//   MVM_RELU_EN  when defined, negative inputs are forced to 0 before the shift.
//                Ports are identical either way.

module mvm3_result_quant_buf #(
    parameter int unsigned NROWS_A = 3,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned SHIFT   = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    input  logic [15:0] i_data_in,
    input  logic        i_ovf_in,
    output logic        o_m_valid,
    input  logic        i_m_ready,
    output logic [7:0]  o_data_out,
    output logic        o_ovf_out,
    output logic        o_sat_out,
    output logic        o_m_last
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RW = (NROWS_A > 1) ? $clog2(NROWS_A) : 1;

    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [RW-1:0] ROW_LAST   = RW'(NROWS_A - 1);

    logic [7:0]    r_mem_data [DEPTH];
    logic          r_mem_ovf  [DEPTH];
    logic          r_mem_sat  [DEPTH];
    logic          r_mem_last [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [RW-1:0] r_row;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic signed [15:0]  w_v;
    logic signed [15:0]  w_t;
    logic                w_sat_hi;
    logic                w_sat_lo;
    logic [7:0]          w_q;
    logic                w_sat;
    logic                w_last;

    // ---------------- handshake ----------------
    assign w_full    = (r_count == COUNT_FULL);
    assign w_empty   = (r_count == '0);
    assign o_s_ready = ~w_full;
    assign o_m_valid = ~w_empty;

    // Full blocks a push even if a pop happens in the same cycle (no bypass).
    assign w_push = i_s_valid & ~w_full;
    assign w_pop  = ~w_empty & i_m_ready;

    // ---------------- quantise (push path) ----------------
`ifdef MVM_RELU_EN
    assign w_v = i_data_in[15] ? 16'sd0 : $signed(i_data_in);
`else
    assign w_v = $signed(i_data_in);
`endif

    assign w_t      = w_v >>> SHIFT;
    assign w_sat_hi = (w_t > 16'sd127);
    assign w_sat_lo = (w_t < -16'sd128);
    assign w_sat    = w_sat_hi | w_sat_lo;

    always_comb begin
        w_q = w_t[7:0];
        if (w_sat_hi) begin
            w_q = 8'h7f;
        end else if (w_sat_lo) begin
            w_q = 8'h80;
        end
    end

    assign w_last = (r_row == ROW_LAST);

    // ---------------- FIFO storage ----------------
    // Storage needs no reset: every read is gated by a non-zero count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_q;
            r_mem_ovf[r_wr_ptr]  <= i_ovf_in;
            r_mem_sat[r_wr_ptr]  <= w_sat;
            r_mem_last[r_wr_ptr] <= w_last;
        end
    end

    // ---------------- pointers, count, row counter ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_row    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_last) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + RW'(1);
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- output ----------------
    // Head entry is driven straight from storage; everything reads 0 when empty.
    always_comb begin
        o_data_out = '0;
        o_ovf_out  = 1'b0;
        o_sat_out  = 1'b0;
        o_m_last   = 1'b0;
        if (!w_empty) begin
            o_data_out = r_mem_data[r_rd_ptr];
            o_ovf_out  = r_mem_ovf[r_rd_ptr];
            o_sat_out  = r_mem_sat[r_rd_ptr];
            o_m_last   = r_mem_last[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_mvm3_result_quant_buf.sv
// tb_mvm3_result_quant_buf
//   Directed self-checking bench. Two instances: u_dut0 with SHIFT=0 and
//   u_dut4 with SHIFT=4, sharing clock and reset. Inputs change on negedge,
//   outputs are sampled on negedge, state advances on posedge.

module tb_mvm3_result_quant_buf;

    logic        clk;
    logic        reset;

    logic        s_valid;
    logic        s_ready;
    logic [15:0] data_in;
    logic        ovf_in;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  data_out;
    logic        ovf_out;
    logic        sat_out;
    logic        m_last;

    logic        b_s_valid;
    logic        b_s_ready;
    logic [15:0] b_data_in;
    logic        b_ovf_in;
    logic        b_m_valid;
    logic        b_m_ready;
    logic [7:0]  b_data_out;
    logic        b_ovf_out;
    logic        b_sat_out;
    logic        b_m_last;

    int checks;
    int errors;

    mvm3_result_quant_buf #(
        .NROWS_A (3),
        .DEPTH   (4),
        .SHIFT   (0)
    ) u_dut0 (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_s_valid  (s_valid),
        .o_s_ready  (s_ready),
        .i_data_in  (data_in),
        .i_ovf_in   (ovf_in),
        .o_m_valid  (m_valid),
        .i_m_ready  (m_ready),
        .o_data_out (data_out),
        .o_ovf_out  (ovf_out),
        .o_sat_out  (sat_out),
        .o_m_last   (m_last)
    );

    mvm3_result_quant_buf #(
        .NROWS_A (3),
        .DEPTH   (4),
        .SHIFT   (4)
    ) u_dut4 (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_s_valid  (b_s_valid),
        .o_s_ready  (b_s_ready),
        .i_data_in  (b_data_in),
        .i_ovf_in   (b_ovf_in),
        .o_m_valid  (b_m_valid),
        .i_m_ready  (b_m_ready),
        .o_data_out (b_data_out),
        .o_ovf_out  (b_ovf_out),
        .o_sat_out  (b_sat_out),
        .o_m_last   (b_m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        s_valid   = 1'b0;
        data_in   = '0;
        ovf_in    = 1'b0;
        m_ready   = 1'b0;
        b_s_valid = 1'b0;
        b_data_in = '0;
        b_ovf_in  = 1'b0;
        b_m_ready = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
        checks++; if ({ovf_out, sat_out, m_last} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {ovf_out, sat_out, m_last});
        end
        checks++; if ({b_m_valid, b_s_ready} !== 2'b01) begin
            errors++; $display("FAIL reset_dut4 got %b want 01", {b_m_valid, b_s_ready});
        end
    endtask

    task automatic test_stream();
        logic [15:0] vin   [3] = '{16'd100, 16'hfffb, 16'd300};
        logic [7:0]  e_d   [3] = '{8'd100, 8'hfb, 8'h7f};
        logic        e_sat [3] = '{1'b0, 1'b0, 1'b1};
        logic        e_lst [3] = '{1'b0, 1'b0, 1'b1};
        m_ready = 1'b1;
        s_valid = 1'b1;
        data_in = vin[0];
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b want 1", i, m_valid); end
            checks++; if (data_out !== e_d[i]) begin
                errors++; $display("FAIL stream_data[%0d] got %h want %h", i, data_out, e_d[i]);
            end
            checks++; if (sat_out !== e_sat[i]) begin
                errors++; $display("FAIL stream_sat[%0d] got %b want %b", i, sat_out, e_sat[i]);
            end
            checks++; if (m_last !== e_lst[i]) begin
                errors++; $display("FAIL stream_last[%0d] got %b want %b", i, m_last, e_lst[i]);
            end
            if (i < 2) data_in = vin[i+1];
            else s_valid = 1'b0;
        end
        cycle();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got %b want 0", m_valid); end
    endtask

    task automatic test_full();
        logic [7:0] e_d [3] = '{8'd3, 8'd4, 8'd5};
        logic       e_l [3] = '{1'b1, 1'b0, 1'b0};
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            data_in = 16'(i + 1);
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_ready_pre[%0d] got %b want 1", i, s_ready); end
            cycle();
        end
        data_in = 16'd5;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low got %b want 0", s_ready); end
        checks++; if (data_out !== 8'd1) begin errors++; $display("FAIL full_head got %h want 01", data_out); end
        cycle();
        cycle();
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready got %b want 0", s_ready); end
        checks++; if ({m_valid, data_out} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL full_hold_data got %b/%h want 1/01", m_valid, data_out);
        end
        m_ready = 1'b1;
        cycle();
        // Pop only: full blocked the simultaneous push.
        checks++; if (data_out !== 8'd2) begin errors++; $display("FAIL full_pop1 got %h want 02", data_out); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got %b want 1", s_ready); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (i == 0) s_valid = 1'b0;
            checks++; if ({m_valid, data_out} !== {1'b1, e_d[i]}) begin
                errors++; $display("FAIL full_drain[%0d] got %b/%h want 1/%h", i, m_valid, data_out, e_d[i]);
            end
            checks++; if (m_last !== e_l[i]) begin
                errors++; $display("FAIL full_last[%0d] got %b want %b", i, m_last, e_l[i]);
            end
        end
        cycle();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", m_valid); end
    endtask

    task automatic test_shift();
        logic [15:0] vin [3] = '{16'hf000, 16'd2047, 16'hfff0};
        logic [7:0]  e_d [3] = '{8'h80, 8'h7f, 8'hff};
        logic        e_s [3] = '{1'b1, 1'b0, 1'b0};
        logic        e_l [3] = '{1'b0, 1'b0, 1'b1};
        b_m_ready = 1'b1;
        b_s_valid = 1'b1;
        b_data_in = vin[0];
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if ({b_m_valid, b_data_out} !== {1'b1, e_d[i]}) begin
                errors++; $display("FAIL shift_data[%0d] got %b/%h want 1/%h", i, b_m_valid, b_data_out, e_d[i]);
            end
            checks++; if ({b_sat_out, b_m_last} !== {e_s[i], e_l[i]}) begin
                errors++; $display("FAIL shift_flags[%0d] got %b%b want %b%b", i, b_sat_out, b_m_last, e_s[i], e_l[i]);
            end
            if (i < 2) b_data_in = vin[i+1];
            else b_s_valid = 1'b0;
        end
        cycle();
        checks++; if (b_m_valid !== 1'b0) begin errors++; $display("FAIL shift_drained got %b want 0", b_m_valid); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] e_d [3] = '{8'd7, 8'd8, 8'd9};
        logic       e_l [3] = '{1'b0, 1'b0, 1'b1};
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            data_in = 16'(20 + i);
            cycle();
        end
        s_valid = 1'b0;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL mreset_buffered got %b want 1", m_valid); end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++; if ({m_valid, s_ready} !== 2'b01) begin
            errors++; $display("FAIL mreset_state got %b want 01", {m_valid, s_ready});
        end
        checks++; if ({data_out, m_last} !== 9'd0) begin
            errors++; $display("FAIL mreset_out got %h/%b want 00/0", data_out, m_last);
        end
        m_ready = 1'b1;
        s_valid = 1'b1;
        data_in = 16'd7;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if ({m_valid, data_out, m_last} !== {1'b1, e_d[i], e_l[i]}) begin
                errors++; $display("FAIL mreset_row[%0d] got %b/%h/%b want 1/%h/%b",
                                   i, m_valid, data_out, m_last, e_d[i], e_l[i]);
            end
            if (i < 2) data_in = 16'(8 + i);
            else s_valid = 1'b0;
        end
        cycle();
    endtask

    task automatic test_relu();
        logic [7:0] e_d;
        logic       e_s;
`ifdef MVM_RELU_EN
        e_d = 8'h00;
        e_s = 1'b0;
`else
        e_d = 8'h80;
        e_s = 1'b1;
`endif
        m_ready = 1'b1;
        s_valid = 1'b1;
        ovf_in  = 1'b1;
        data_in = 16'hfed4;  // -300
        cycle();
        s_valid = 1'b0;
        ovf_in  = 1'b0;
        checks++; if ({m_valid, data_out} !== {1'b1, e_d}) begin
            errors++; $display("FAIL relu_data got %b/%h want 1/%h", m_valid, data_out, e_d);
        end
        checks++; if ({ovf_out, sat_out, m_last} !== {1'b1, e_s, 1'b0}) begin
            errors++; $display("FAIL relu_flags got %b want %b", {ovf_out, sat_out, m_last}, {1'b1, e_s, 1'b0});
        end
        cycle();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL relu_drained got %b want 0", m_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_full();
        test_shift();
        test_mid_reset();
        test_relu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
